serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's complement subtractor (a - b), LSB first, for EDSAC short/long words.
// Optional result flags (negative/zero/overflow) are built when SERIAL_SUBTRACTOR_FLAGS_EN is defined.
`timescale 1ns/1ps

module serial_subtractor #(
    parameter int SHORT_LEN = 17,
    parameter int LONG_LEN  = 35
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic long,
    input  logic a,
    input  logic b,
    output logic diff,
    output logic diff_valid,
    output logic word_end,
    output logic busy,
    output logic negative,
    output logic zero,
    output logic overflow
);

    localparam int CNT_W = (LONG_LEN > 1) ? $clog2(LONG_LEN) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_idx;
    logic             borrow;

    logic             sample;
    logic             borrow_in;
    logic             d_bit;
    logic             borrow_out;
    logic             last_bit;
    logic [CNT_W-1:0] new_last_idx;

    // A start always forces a zero borrow-in, which also covers abandoning a word mid-flight.
    always_comb begin
        new_last_idx = long ? CNT_W'(LONG_LEN - 1) : CNT_W'(SHORT_LEN - 1);
        sample       = start || (state == RUN);
        borrow_in    = (state == RUN) && !start && borrow;
        d_bit        = a ^ b ^ borrow_in;
        borrow_out   = (~a & b) | (~(a ^ b) & borrow_in);
        last_bit     = start ? (new_last_idx == '0) : (cnt == last_idx);
    end

    // Sample stage -> registered result bit, one cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_idx   <= '0;
            borrow     <= 1'b0;
            diff       <= 1'b0;
            diff_valid <= 1'b0;
            word_end   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            diff       <= sample & d_bit;
            diff_valid <= sample;
            word_end   <= sample & last_bit;
            if (sample) begin
                borrow <= borrow_out;
                if (start) begin
                    last_idx <= new_last_idx;
                end
                if (last_bit) begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end else begin
                    state <= RUN;
                    busy  <= 1'b1;
                    cnt   <= start ? CNT_W'(1) : cnt + CNT_W'(1);
                end
            end else begin
                borrow <= 1'b0;
                busy   <= 1'b0;
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic zero_acc;
    logic zero_run;

    // Running "all bits so far were zero", restarted by every start.
    always_comb begin
        zero_run = (start ? 1'b1 : zero_acc) & ~d_bit;
    end

    // Flag stage: committed only when the MSB of a completed word is sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_acc <= 1'b1;
            negative <= 1'b0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else if (sample) begin
            zero_acc <= zero_run;
            if (last_bit) begin
                negative <= d_bit;
                zero     <= zero_run;
                overflow <= (a ^ b) & (a ^ d_bit);
            end
        end
    end
`else
    assign negative = 1'b0;
    assign zero     = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: fixed word vectors, corner sequences, and a
// randomized stream compared against a word-level arithmetic reference model.
`timescale 1ns/1ps

module tb_serial_subtractor;

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    localparam int SN   = 17;
    localparam int LN   = 35;
    localparam int SLEN = 1500;

    logic clk = 1'b0;
    logic rst_n, start, long, a, b;
    logic diff, diff_valid, word_end, busy, negative, zero, overflow;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.SHORT_LEN(SN), .LONG_LEN(LN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .long(long), .a(a), .b(b),
        .diff(diff), .diff_valid(diff_valid), .word_end(word_end), .busy(busy),
        .negative(negative), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        bit     lng;
        longint av;
        longint bv;
        longint d;
        bit     neg;
        bit     zro;
        bit     ovf;
    } vec_t;

    vec_t tbl[7];

    // Stream stimulus and word-level expectations, index c = outputs after the edge ending cycle c
    bit st[SLEN], lg[SLEN], av[SLEN], bv[SLEN];
    bit ex_diff[SLEN], ex_vld[SLEN], ex_end[SLEN], ex_busy[SLEN];
    bit ex_neg[SLEN], ex_zero[SLEN], ex_ovf[SLEN];
    bit cmp_set[SLEN], cmp_neg[SLEN], cmp_zero[SLEN], cmp_ovf[SLEN];
    bit obs_end[SLEN];

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_stream();
        for (int c = 0; c < SLEN; c++) begin
            st[c] = 0; lg[c] = 0; av[c] = 0; bv[c] = 0;
        end
    endtask

    task automatic build_model();
        bit cn, cz, co;
        for (int c = 0; c < SLEN; c++) begin
            ex_diff[c] = 0; ex_vld[c] = 0; ex_end[c] = 0; ex_busy[c] = 0;
            cmp_set[c] = 0; cmp_neg[c] = 0; cmp_zero[c] = 0; cmp_ovf[c] = 0;
        end
        for (int c = 0; c < SLEN; c++) begin
            if (st[c]) begin
                int     n, len;
                longint wa, wb, dv, mask, sa, sb, r, half;
                n   = lg[c] ? LN : SN;
                len = n;
                for (int j = c + 1; j < c + n && j < SLEN; j++) begin
                    if (st[j]) begin
                        len = j - c;
                        break;
                    end
                end
                wa = 0; wb = 0;
                for (int i = 0; i < len; i++) begin
                    wa |= longint'(av[c+i]) << i;
                    wb |= longint'(bv[c+i]) << i;
                end
                mask = (longint'(1) << n) - 1;
                half = longint'(1) << (n - 1);
                dv   = (wa - wb) & mask;
                for (int i = 0; i < len; i++) begin
                    ex_vld[c+i]  = 1;
                    ex_diff[c+i] = dv[i];
                    ex_busy[c+i] = (i < n - 1);
                end
                if (len == n) begin
                    sa = (wa >= half) ? wa - (longint'(1) << n) : wa;
                    sb = (wb >= half) ? wb - (longint'(1) << n) : wb;
                    r  = sa - sb;
                    ex_end[c+n-1]   = 1;
                    cmp_set[c+n-1]  = 1;
                    cmp_neg[c+n-1]  = (dv >= half);
                    cmp_zero[c+n-1] = (dv == 0);
                    cmp_ovf[c+n-1]  = (r > half - 1) || (r < -half);
                end
            end
        end
        cn = 0; cz = 1; co = 0;
        for (int c = 0; c < SLEN; c++) begin
            if (cmp_set[c]) begin
                cn = cmp_neg[c]; cz = cmp_zero[c]; co = cmp_ovf[c];
            end
            ex_neg[c] = cn; ex_zero[c] = cz; ex_ovf[c] = co;
        end
    endtask

    task automatic run_stream(input string tag);
        logic [6:0] got, exp;
        build_model();
        do_reset();
        for (int c = 0; c < SLEN; c++) begin
            start = st[c]; long = lg[c]; a = av[c]; b = bv[c];
            @(posedge clk); #1;
            obs_end[c] = word_end;
            got = {diff, diff_valid, word_end, busy, negative, zero, overflow};
            exp = {ex_diff[c], ex_vld[c], ex_end[c], ex_busy[c],
                   ex_neg[c] & FL, ex_zero[c] & FL, ex_ovf[c] & FL};
            chk($sformatf("%s cycle %0d {diff,vld,end,busy,neg,zero,ovf}", tag, c),
                64'(got), 64'(exp));
        end
        start = 1'b0;
    endtask

    // Drives one isolated word; outputs sampled after edges t+1..t+N
    task automatic run_word(input bit lng, input longint wa, input longint wb,
                            output longint got, output int end_at,
                            output bit vld_ok, output bit busy_ok);
        int n;
        n = lng ? LN : SN;
        got = 0; end_at = -1; vld_ok = 1; busy_ok = 1;
        start = 1'b1; long = lng; a = wa[0]; b = wb[0];
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            got |= longint'(diff) << (k - 1);
            if (!diff_valid) vld_ok = 0;
            if (busy !== (k < n)) busy_ok = 0;
            if (word_end && end_at < 0) end_at = k;
            start = 1'b0;
            long  = 1'($urandom);
            a     = (k < n) ? wa[k] : 1'b0;
            b     = (k < n) ? wb[k] : 1'b0;
        end
    endtask

    initial begin
        longint got;
        int     end_at, n;
        bit     vld_ok, busy_ok, saw_end, force_start;

        tbl[0] = '{0, 64'h5,         64'h3,         64'h00002,     0, 0, 0};
        tbl[1] = '{0, 64'h0,         64'h1,         64'h1FFFF,     1, 0, 0};
        tbl[2] = '{0, 64'h3,         64'h3,         64'h00000,     0, 1, 0};
        tbl[3] = '{0, 64'h10000,     64'h1,         64'h0FFFF,     0, 0, 1};
        tbl[4] = '{1, 64'h400000000, 64'h000000001, 64'h3FFFFFFFF, 0, 0, 1};
        tbl[5] = '{0, 64'h0FFFF,     64'h1FFFF,     64'h10000,     1, 0, 1};
        tbl[6] = '{1, 64'h0,         64'h0,         64'h0,         0, 1, 0};

        rst_n = 1'b0; start = 1'b0; long = 1'b0; a = 1'b0; b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset {diff,vld,end,busy}", 64'({diff, diff_valid, word_end, busy}), 64'h0);
        chk("reset {neg,zero,ovf}", 64'({negative, zero, overflow}), 64'({1'b0, FL, 1'b0}));
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            n = tbl[i].lng ? LN : SN;
            run_word(tbl[i].lng, tbl[i].av, tbl[i].bv, got, end_at, vld_ok, busy_ok);
            chk($sformatf("vec%0d diff", i), 64'(got), 64'(tbl[i].d));
            chk($sformatf("vec%0d word_end cycle", i), 64'(end_at), 64'(n));
            chk($sformatf("vec%0d diff_valid", i), 64'(vld_ok), 64'h1);
            chk($sformatf("vec%0d busy", i), 64'(busy_ok), 64'h1);
            chk($sformatf("vec%0d {neg,zero,ovf}", i), 64'({negative, zero, overflow}),
                64'({tbl[i].neg & FL, tbl[i].zro & FL, tbl[i].ovf & FL}));
            start = 1'b0; a = 1'b1; b = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("vec%0d idle {diff,vld,end,busy}", i),
                64'({diff, diff_valid, word_end, busy}), 64'h0);
            chk($sformatf("vec%0d flags held", i), 64'({negative, zero, overflow}),
                64'({tbl[i].neg & FL, tbl[i].zro & FL, tbl[i].ovf & FL}));
        end

        // Long word immediately followed by a short word
        clear_stream();
        st[0] = 1; lg[0] = 1;
        av[34] = 1; bv[0] = 1;
        st[35] = 1; lg[35] = 0;
        av[35] = 1; av[37] = 1; bv[35] = 1; bv[36] = 1;
        run_stream("b2b");
        chk("b2b long word_end at t+35", 64'(obs_end[34]), 64'h1);
        chk("b2b short word_end at t+52", 64'(obs_end[51]), 64'h1);

        // Restart mid-word, then asynchronous reset mid-word
        do_reset();
        saw_end = 0;
        for (int c = 0; c < 12; c++) begin
            start = (c == 0 || c == 8); long = 1'b0;
            a = 1'($urandom); b = 1'($urandom);
            @(posedge clk); #1;
            saw_end |= word_end;
        end
        start = 1'b0;
        chk("restart busy", 64'(busy), 64'h1);
        chk("restart flags untouched", 64'({negative, zero, overflow}), 64'({1'b0, FL, 1'b0}));
        #2 rst_n = 1'b0;
        #1;
        chk("async reset {diff,vld,end,busy}", 64'({diff, diff_valid, word_end, busy}), 64'h0);
        chk("async reset flags", 64'({negative, zero, overflow}), 64'({1'b0, FL, 1'b0}));
        chk("restart no word_end", 64'(saw_end), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_word(0, 64'h5, 64'h3, got, end_at, vld_ok, busy_ok);
        chk("post-reset diff", 64'(got), 64'h2);
        chk("post-reset word_end cycle", 64'(end_at), 64'(SN));
        start = 1'b0;

        // Randomized stream with gaps, back-to-back words and abandoned words
        clear_stream();
        begin
            int c, gap, len;
            bit lng;
            c = 0; force_start = 0;
            while (c < SLEN - 60) begin
                gap = (force_start || $urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) begin
                    lg[c] = 1'($urandom); av[c] = 1'($urandom); bv[c] = 1'($urandom);
                    c++;
                end
                lng = 1'($urandom);
                n   = lng ? LN : SN;
                len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, n - 1) : n;
                force_start = (len < n);
                st[c] = 1; lg[c] = lng;
                for (int i = 0; i < len; i++) begin
                    if (i > 0) lg[c+i] = 1'($urandom);
                    av[c+i] = 1'($urandom);
                    bv[c+i] = 1'($urandom);
                end
                c += len;
            end
        end
        run_stream("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
